sar_adc_oversample: RTL and testbench
=====================================

// Module: sar_adc_oversample
// PURPOSE
//  Parametrised successive-approximation ADC controller, successor to the fixed 14-bit SAR controller.
//  Drives external sample/hold and serial-loaded DAC (ser/sclk/lclk), reads the analogue comparator.
//  Adds: configurable resolution/timing, single-shot or continuous mode, 2^N oversampling with averaging,
//  valid/ready result handshake with overrun flag. Sits between the PLL clock domain and downstream logic.
// PARAMETERS
//  WIDTH         14  conversion resolution in bits (= DAC word length)
//  CLK_DIV       4   clk_i cycles per sclk_o half-period (>=1)
//  SH_CYCLES     36  clk_i cycles sh_o held high (track) per sample
//  SETTLE_CYCLES 18  clk_i cycles after lclk_o falls before comp_i sampled (>=3, covers 2-FF sync)
//  MAX_OSR_LOG2  4   largest oversampling exponent supported
// PORTS
//  clk_i         in   1      system clock (PLL output)
//  reset_ni      in   1      asynchronous, active-low reset
//  start_i       in   1      start conversion (single-shot); ignored while busy_o
//  continuous_i  in   1      1: restart automatically after each result
//  osr_log2_i    in   3      oversampling exponent N; 2^N conversions averaged; captured at start
//  sh_o          out  1      1 = track, 0 = hold
//  ser_o         out  1      DAC serial data, MSB first
//  sclk_o        out  1      DAC shift clock; ser_o stable on rising edge
//  lclk_o        out  1      DAC latch clock; one CLK_DIV-wide high pulse per word
//  comp_i        in   1      comparator, 1 = Vin >= DAC output; asynchronous
//  data_o        out  WIDTH  averaged result; stable while data_valid_o
//  data_valid_o  out  1      result available
//  data_ready_i  in   1      consumer accepts result when valid & ready
//  busy_o        out  1      conversion sequence in progress
//  overrun_o     out  1      one-cycle pulse: new result overwrote unaccepted one
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, FSM IDLE, accumulator/result cleared.
//  FSM: IDLE -> TRACK -> (per bit) SHIFT -> LATCH -> SETTLE -> DECIDE -> ... -> ACCUM -> IDLE/TRACK.
//   IDLE: busy_o=0; start_i=1 (or continuous_i=1) -> TRACK; capture N=min(osr_log2_i,MAX_OSR_LOG2).
//   TRACK: sh_o=1 for SH_CYCLES, then sh_o=0 (hold), bit index k=WIDTH-1, code=0.
//   SHIFT: trial=code|(1<<k); shift WIDTH bits MSB first, 2*CLK_DIV clk_i per bit; sclk_o idle low.
//   LATCH: lclk_o=1 for CLK_DIV cycles. SETTLE: wait SETTLE_CYCLES.
//   DECIDE: synced comp_i=1 -> code=trial, else keep code; k==0 -> ACCUM else k-1, SHIFT.
//   ACCUM: acc+=code (acc width WIDTH+MAX_OSR_LOG2, never overflows); count<2^N-1 -> TRACK;
//    else data_o<=acc>>N (truncate), data_valid_o=1, acc cleared, then IDLE (or TRACK if continuous_i).
//  N=0: data_o equals single conversion code exactly.
//  Handshake: data_valid_o held until cycle with data_ready_i=1 (clears next cycle).
//   New result while valid still high: data_o overwritten, data_valid_o stays 1, overrun_o pulses.
//   Accept and new result in same cycle: new result wins, valid stays 1, no overrun.
//  start_i while busy_o ignored; continuous_i deasserted mid-sequence: finish current result, then IDLE.
//  comp_i passes 2-FF synchroniser; only sampled in DECIDE.
//  Per conversion: WIDTH*WIDTH sclk_o pulses, WIDTH lclk_o pulses, one sh_o pulse.
// STRUCTURE
//  Package sar_adc_pkg: FSM state enum, sclk/lclk timing constants, acc_width function (WIDTH+MAX_OSR_LOG2).
//  Sub-module sar_dac_shifter: loads WIDTH-bit word on load strobe, generates ser_o/sclk_o/lclk_o,
//   pulses done after latch; top handles FSM, SAR register, accumulator, handshake.
// TESTING (bench: behavioural DAC+comparator model, comp = Vin_code >= latched DAC word; WIDTH=14)
//  1 reset mid-idle and after: all outputs 0; data_valid_o=0; busy_o=0.
//  2 Vin=0x1234, N=0, start pulse -> data_o=0x1234, valid; 196 sclk, 14 lclk, 1 sh pulse counted.
//  3 Vin=0x0000 -> 0x0000; Vin=0x3FFF -> 0x3FFF; Vin=0x2000 -> 0x2000 (MSB boundary).
//  4 N=2, model Vin 100,101,102,103 per sample -> 4 sh pulses, data_o=101 (406>>2); osr_log2_i=7 -> N=4.
//  5 continuous_i=1, data_ready_i=0 -> 2nd result overwrites, overrun_o one-cycle pulse; ready=1 clears valid.
//  6 reset_ni low during bit 7 SHIFT -> outputs 0 same cycle; after release, Vin=0x0ABC converts correctly.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and sizing helpers for the oversampling SAR ADC controller
// and its serial DAC shifter.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRACK,
    ST_SHIFT,
    ST_LATCH,
    ST_SETTLE,
    ST_DECIDE,
    ST_ACCUM
  } sar_state_e;

  typedef enum logic [1:0] {
    DAC_IDLE,
    DAC_LOW,
    DAC_HIGH,
    DAC_LATCH
  } dac_state_e;

  // comp_i is asynchronous to clk_i, so it crosses a two-flop synchroniser
  localparam int SYNC_STAGES = 2;

  function automatic int acc_width(input int width, input int max_osr_log2);
    return width + max_osr_log2;
  endfunction

  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sar_dac_shifter.sv
// Serialises one DAC word MSB first on ser_o/sclk_o, then pulses lclk_o for
// CLK_DIV cycles; done_o pulses once the latch pulse has ended.
module sar_dac_shifter
  import sar_adc_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int CLK_DIV = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             ser_o,
  output logic             sclk_o,
  output logic             lclk_o,
  output logic             done_o
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam int BW = cnt_width(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  dac_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic             ser_q;
  logic             sclk_q;
  logic             lclk_q;
  logic             done_q;
  logic             div_wrap_d;

  assign div_wrap_d = (div_q == DIV_LAST);

  // ser_q changes at the start of the low half so it is stable at the sclk rise
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= DAC_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      lclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DAC_IDLE: begin
          if (load_i) begin
            ser_q   <= word_i[WIDTH-1];
            shreg_q <= word_i << 1;
            bit_q   <= '0;
            div_q   <= '0;
            state_q <= DAC_LOW;
          end
        end
        DAC_LOW: begin
          if (div_wrap_d) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= DAC_HIGH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        DAC_HIGH: begin
          if (div_wrap_d) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              ser_q   <= 1'b0;
              lclk_q  <= 1'b1;
              state_q <= DAC_LATCH;
            end else begin
              bit_q   <= bit_q + 1'b1;
              ser_q   <= shreg_q[WIDTH-1];
              shreg_q <= shreg_q << 1;
              state_q <= DAC_LOW;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        DAC_LATCH: begin
          if (div_wrap_d) begin
            div_q   <= '0;
            lclk_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DAC_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= DAC_IDLE;
      endcase
    end
  end

  assign ser_o  = ser_q;
  assign sclk_o = sclk_q;
  assign lclk_o = lclk_q;
  assign done_o = done_q;

endmodule

// File: rtl/sar_adc_oversample.sv
// SAR ADC controller: track/hold, binary search through the serial DAC,
// 2^N oversampling with averaging and a valid/ready result port with overrun.
module sar_adc_oversample
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 14,
  parameter int CLK_DIV       = 4,
  parameter int SH_CYCLES     = 36,
  parameter int SETTLE_CYCLES = 18,
  parameter int MAX_OSR_LOG2  = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic [2:0]       osr_log2_i,
  output logic             sh_o,
  output logic             ser_o,
  output logic             sclk_o,
  output logic             lclk_o,
  input  logic             comp_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int AW = acc_width(WIDTH, MAX_OSR_LOG2);
  localparam int TW = cnt_width((SH_CYCLES > SETTLE_CYCLES) ? SH_CYCLES : SETTLE_CYCLES);
  localparam int KW = cnt_width(WIDTH - 1);
  localparam int CW = MAX_OSR_LOG2 + 1;
  localparam logic [2:0]       OSR_MAX     = 3'(MAX_OSR_LOG2);
  localparam logic [TW-1:0]    SH_LAST     = TW'(SH_CYCLES - 1);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [KW-1:0]    K_MSB       = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_WORD    = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e             state_q;
  logic [TW-1:0]          tmr_q;
  logic [KW-1:0]          k_q;
  logic [WIDTH-1:0]       code_q;
  logic [WIDTH-1:0]       dac_word_q;
  logic                   load_q;
  logic [AW-1:0]          acc_q;
  logic [CW-1:0]          conv_cnt_q;
  logic [2:0]             osr_q;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   overrun_q;
  logic                   sh_q;
  logic                   busy_q;
  logic [SYNC_STAGES-1:0] comp_sync_q;

  logic                   comp_s;
  logic                   lclk_w;
  logic                   dac_done_w;
  logic [2:0]             osr_clamp_d;
  logic [WIDTH-1:0]       code_new_d;
  logic [WIDTH-1:0]       next_word_d;
  logic [AW-1:0]          acc_sum_d;
  logic [WIDTH-1:0]       avg_d;
  logic [CW-1:0]          conv_last_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      comp_sync_q <= '0;
    end else begin
      comp_sync_q <= {comp_sync_q[SYNC_STAGES-2:0], comp_i};
    end
  end

  assign comp_s = comp_sync_q[SYNC_STAGES-1];

  // The word on the DAC is always the current trial, so a 1 decision adopts it
  always_comb begin
    osr_clamp_d = (osr_log2_i > OSR_MAX) ? OSR_MAX : osr_log2_i;
    code_new_d  = comp_s ? dac_word_q : code_q;
    next_word_d = code_new_d | (WIDTH'(1) << (k_q - 1'b1));
    acc_sum_d   = acc_q + AW'(code_q);
    avg_d       = WIDTH'(acc_sum_d >> osr_q);
    conv_last_d = (CW'(1) << osr_q) - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      k_q        <= '0;
      code_q     <= '0;
      dac_word_q <= '0;
      load_q     <= 1'b0;
      acc_q      <= '0;
      conv_cnt_q <= '0;
      osr_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sh_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      overrun_q <= 1'b0;
      if (valid_q && data_ready_i) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i || continuous_i) begin
            osr_q      <= osr_clamp_d;
            conv_cnt_q <= '0;
            acc_q      <= '0;
            tmr_q      <= '0;
            sh_q       <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (tmr_q == SH_LAST) begin
            sh_q       <= 1'b0;
            k_q        <= K_MSB;
            code_q     <= '0;
            dac_word_q <= MSB_WORD;
            load_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (lclk_w) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (dac_done_w) begin
            tmr_q   <= '0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_q <= ST_DECIDE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          code_q <= code_new_d;
          if (k_q == '0) begin
            state_q <= ST_ACCUM;
          end else begin
            k_q        <= k_q - 1'b1;
            dac_word_q <= next_word_d;
            load_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_ACCUM: begin
          tmr_q <= '0;
          if (conv_cnt_q != conv_last_d) begin
            acc_q      <= acc_sum_d;
            conv_cnt_q <= conv_cnt_q + 1'b1;
            sh_q       <= 1'b1;
            state_q    <= ST_TRACK;
          end else begin
            // A same-cycle accept frees the slot, so only an unaccepted result overruns
            data_q     <= avg_d;
            valid_q    <= 1'b1;
            overrun_q  <= valid_q && !data_ready_i;
            acc_q      <= '0;
            conv_cnt_q <= '0;
            if (continuous_i) begin
              osr_q   <= osr_clamp_d;
              sh_q    <= 1'b1;
              state_q <= ST_TRACK;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sar_dac_shifter #(
    .WIDTH  (WIDTH),
    .CLK_DIV(CLK_DIV)
  ) u_dac (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .load_i  (load_q),
    .word_i  (dac_word_q),
    .ser_o   (ser_o),
    .sclk_o  (sclk_o),
    .lclk_o  (lclk_w),
    .done_o  (dac_done_w)
  );

  assign lclk_o       = lclk_w;
  assign sh_o         = sh_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sar_adc_oversample.sv
// Bench for sar_adc_oversample: behavioural serial DAC + ideal comparator,
// table-driven and random conversions against an averaging reference.
`timescale 1ns/1ps
module tb_sar_adc_oversample;

  localparam int WIDTH         = 14;
  localparam int CLK_DIV       = 2;
  localparam int SH_CYCLES     = 12;
  localparam int SETTLE_CYCLES = 6;
  localparam int MAX_OSR_LOG2  = 4;
  localparam int CONV_BUDGET   = 1500;

  logic             clk_i = 1'b0;
  logic             reset_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             continuous_i = 1'b0;
  logic [2:0]       osr_log2_i = 3'd0;
  logic             data_ready_i = 1'b0;
  logic             comp_i;
  logic             sh_o, ser_o, sclk_o, lclk_o, data_valid_o, busy_o, overrun_o;
  logic [WIDTH-1:0] data_o;

  always #5 clk_i = ~clk_i;

  sar_adc_oversample #(
    .WIDTH        (WIDTH),
    .CLK_DIV      (CLK_DIV),
    .SH_CYCLES    (SH_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_OSR_LOG2 (MAX_OSR_LOG2)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .continuous_i(continuous_i),
    .osr_log2_i  (osr_log2_i),
    .sh_o        (sh_o),
    .ser_o       (ser_o),
    .sclk_o      (sclk_o),
    .lclk_o      (lclk_o),
    .comp_i      (comp_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  // Analogue side: Vin for sample i of a sequence is vin_base + vin_step*i
  int unsigned vin_base = 0, vin_step = 0, seq_base = 0, vin_cur = 0;
  int unsigned sh_falls = 0, sh_hi = 0, sclk_rises = 0, lclk_rises = 0, ovr_cnt = 0;
  logic [WIDTH-1:0] dac_sr = '0, dac_lat = '0;

  always @(posedge sclk_o) begin
    dac_sr <= {dac_sr[WIDTH-2:0], ser_o};
    sclk_rises++;
  end
  always @(posedge lclk_o) begin
    dac_lat <= dac_sr;
    lclk_rises++;
  end
  always @(negedge sh_o) begin
    vin_cur = vin_base + vin_step * (sh_falls - seq_base);
    sh_falls++;
  end
  always @(negedge clk_i) begin
    if (sh_o) sh_hi++;
    if (overrun_o) ovr_cnt++;
  end
  assign comp_i = (vin_cur >= 32'(dac_lat));

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (data_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {sh_o, ser_o, sclk_o, lclk_o, data_valid_o, busy_o, overrun_o}, 0);
    check({name, "_data"}, data_o, 0);
  endtask

  function automatic int unsigned model_avg(input int unsigned vin, input int unsigned step,
                                            input int n);
    int unsigned sum = 0;
    for (int i = 0; i < (1 << n); i++) sum += vin + step * i;
    return sum >> n;
  endfunction

  // One start-triggered result: checks data, pulse counts, busy, then accepts
  task automatic run_conv(input string name, input int unsigned vin, input int unsigned step,
                          input logic [2:0] osr, input int unsigned exp_data, input int convs);
    int unsigned s0, sc0, l0, h0;
    bit ok;
    vin_base = vin; vin_step = step; seq_base = sh_falls;
    s0 = sh_falls; sc0 = sclk_rises; l0 = lclk_rises; h0 = sh_hi;
    osr_log2_i = osr;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    osr_log2_i = 3'd0;
    check({name, "_busy"}, busy_o, 1);
    repeat (50) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid(CONV_BUDGET * convs, ok);
    check({name, "_done_in_time"}, ok, 1);
    check({name, "_data"}, data_o, exp_data);
    check({name, "_idle"}, busy_o, 0);
    check({name, "_sh_pulses"}, sh_falls - s0, convs);
    check({name, "_sh_cycles"}, sh_hi - h0, convs * SH_CYCLES);
    check({name, "_sclk"}, sclk_rises - sc0, convs * WIDTH * WIDTH);
    check({name, "_lclk"}, lclk_rises - l0, convs * WIDTH);
    tick();
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    @(negedge clk_i);
    check({name, "_valid_cleared"}, data_valid_o, 0);
    repeat (5) @(negedge clk_i);
    check({name, "_no_restart"}, busy_o, 0);
  endtask

  typedef struct {
    int unsigned vin;
    int unsigned step;
    logic [2:0]  osr;
    int unsigned exp_data;
    int          convs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int unsigned o0, l0, sc0;

    vecs[0] = '{'h1234, 0, 3'd0, 'h1234, 1};
    vecs[1] = '{'h0000, 0, 3'd0, 'h0000, 1};
    vecs[2] = '{'h3FFF, 0, 3'd0, 'h3FFF, 1};
    vecs[3] = '{'h2000, 0, 3'd0, 'h2000, 1};
    vecs[4] = '{100,    1, 3'd2, 101,     4};
    vecs[5] = '{100,    1, 3'd7, 107,     16};

    // reset state
    #3;
    check_all_zero("reset_initial");
    tick();
    reset_ni = 1'b1;
    repeat (3) tick();

    run_conv("vec0", vecs[0].vin, vecs[0].step, vecs[0].osr, vecs[0].exp_data, vecs[0].convs);

    // reset while idle with an old result held
    #2;
    reset_ni = 1'b0;
    #1;
    check_all_zero("reset_idle");
    tick();
    reset_ni = 1'b1;
    repeat (2) tick();

    for (int i = 1; i < 6; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].vin, vecs[i].step, vecs[i].osr,
               vecs[i].exp_data, vecs[i].convs);

    for (int r = 0; r < 4; r++) begin
      int unsigned v, s;
      int n;
      n = int'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      v = $urandom_range(0, 'h3FFF - 3);
      run_conv($sformatf("rand%0d", r), v, s, 3'(n), model_avg(v, s, n), 1 << n);
    end

    // continuous mode with the consumer stalled
    vin_base = 'h0100; vin_step = 'h11; seq_base = sh_falls; o0 = ovr_cnt;
    data_ready_i = 1'b0;
    continuous_i = 1'b1;
    tick();
    wait_valid(CONV_BUDGET, ok);
    check("cont_first_in_time", ok, 1);
    check("cont_first_data", data_o, 'h0100);
    check("cont_first_no_overrun", ovr_cnt - o0, 0);
    ok = 1'b0;
    for (int i = 0; i < CONV_BUDGET; i++) begin
      @(negedge clk_i);
      if (overrun_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_overrun_seen", ok, 1);
    check("cont_second_data", data_o, 'h0111);
    check("cont_second_valid", data_valid_o, 1);
    @(negedge clk_i);
    check("cont_overrun_one_cycle", overrun_o, 0);
    continuous_i = 1'b0;
    tick();
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    @(negedge clk_i);
    check("cont_accept_clears", data_valid_o, 0);
    wait_valid(CONV_BUDGET, ok);
    check("cont_third_in_time", ok, 1);
    check("cont_third_data", data_o, 'h0122);
    check("cont_overrun_total", ovr_cnt - o0, 1);
    repeat (5) @(negedge clk_i);
    check("cont_stopped", busy_o, 0);
    tick();
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;

    // reset during the bit-7 word shift, then a clean conversion
    vin_base = 'h0ABC; vin_step = 0; seq_base = sh_falls;
    l0 = lclk_rises; sc0 = sclk_rises;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < CONV_BUDGET; i++) begin
      @(negedge clk_i);
      if ((lclk_rises - l0) == 6 && (sclk_rises - sc0) == 6 * WIDTH + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_bit7", ok, 1);
    check("rst_mid_busy_before", busy_o, 1);
    #2;
    reset_ni = 1'b0;
    #1;
    check_all_zero("reset_mid_shift");
    tick();
    reset_ni = 1'b1;
    repeat (2) tick();
    run_conv("after_reset", 'h0ABC, 0, 3'd0, 'h0ABC, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
